// File: rtl/lifo_pkg.sv
// lifo_pkg: shared op encodings, FSM states and LIFO geometry for the LIFO command front-end
package lifo_pkg;
  localparam int LIFO_DEPTH = 4;
  localparam int LIFO_DW = 4;
  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CLR  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;
  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_t;
endpackage

// File: rtl/lifo_cmd_ctrl.sv
// lifo_cmd_ctrl: valid/ready command front-end sequencing a 4x4 LIFO (push/pop/clear, one response per command, shadow occupancy guards overflow/underflow, sticky sync_err on flag disagreement); ports: clk, Rst, cmd_* in, rsp_* out, lifo_* pin drive and LIFO status in
module lifo_cmd_ctrl
  import lifo_pkg::*;
#(
  parameter int DATA_W = LIFO_DW,
  parameter int DEPTH = LIFO_DEPTH
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              sync_err,
  output logic              lifo_en,
  output logic              lifo_rw,
  output logic              lifo_rst,
  output logic [DATA_W-1:0] lifo_din,
  input  logic [DATA_W-1:0] lifo_dout,
  input  logic              lifo_full,
  input  logic              lifo_empty
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  state_t st, nst;
  op_t op_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0] count;
  logic illegal;
  always_comb begin
    illegal = (cmd_op == OP_RSVD) || (cmd_op == OP_PUSH && count == FULLC) || (cmd_op == OP_POP && count == '0);
    nst = st == INIT  ? IDLE :
          st == IDLE  ? (cmd_valid ? (illegal ? RESP : ISSUE) : IDLE) :
          st == ISSUE ? CAPT :
          st == CAPT  ? RESP :
          (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      st <= INIT;
      op_q <= OP_PUSH;
      data_q <= '0;
      count <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      st <= nst;
      case (st)
        INIT: count <= '0;
        IDLE: if (cmd_valid) begin
          op_q <= op_t'(cmd_op);
          data_q <= cmd_data;
          rsp_err <= illegal;
          rsp_data <= '0;
        end
        ISSUE: count <= op_q == OP_PUSH ? count + 1'b1 : op_q == OP_POP ? count - 1'b1 : '0;
        CAPT: begin
          rsp_data <= op_q == OP_POP ? lifo_dout : '0;
          sync_err <= sync_err || (lifo_full != (count == FULLC)) || (lifo_empty != (count == '0));
        end
        RESP: if (rsp_ready) rsp_err <= 1'b0;
        default: ;
      endcase
    end
  end
  // Pin outputs are gated by Rst so they drop to idle values the moment reset asserts, even though the state register sits in INIT.
  always_comb begin
    cmd_ready = !Rst && st == IDLE;
    rsp_valid = !Rst && st == RESP;
    lifo_en = !Rst && (st == INIT || st == ISSUE);
    lifo_rst = !Rst && (st == INIT || (st == ISSUE && op_q == OP_CLR));
    lifo_rw = !Rst && st == ISSUE && op_q == OP_POP;
    lifo_din = (!Rst && st == ISSUE && op_q == OP_PUSH) ? data_q : '0;
  end
endmodule

// File: tb/tb_lifo_cmd_ctrl.sv
// tb_lifo_cmd_ctrl: scoreboard bench for lifo_cmd_ctrl with a behavioural 4x4 LIFO beside it
module tb_lifo_cmd_ctrl;
  logic clk = 0, Rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_err, sync_err;
  logic [1:0] cmd_op = 0;
  logic [3:0] cmd_data = 0, rsp_data, lifo_din, lifo_dout = 0;
  logic lifo_en, lifo_rw, lifo_rst, lifo_full, lifo_empty;
  logic [3:0] stk [4];
  logic [2:0] sp = 0;
  int nt = 0, nf = 0;
  typedef struct {logic err; logic [3:0] data; int lat;} exp_t;
  exp_t sbq[$];

  lifo_cmd_ctrl dut (.clk(clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sync_err(sync_err), .lifo_en(lifo_en), .lifo_rw(lifo_rw), .lifo_rst(lifo_rst), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .lifo_full(lifo_full), .lifo_empty(lifo_empty));

  always #5 clk = ~clk;

  assign lifo_full = sp == 3'd4;
  assign lifo_empty = sp == 3'd0;
  always @(posedge clk)
    if (lifo_en) begin
      if (lifo_rst) sp <= 0;
      else if (!lifo_rw) begin
        if (sp < 3'd4) begin stk[sp[1:0]] <= lifo_din; sp <= sp + 3'd1; end
      end else if (sp > 3'd0) begin
        lifo_dout <= stk[2'(sp - 3'd1)];
        sp <= sp - 3'd1;
      end
    end

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, output logic err, output logic [3:0] data,
                        output int lat, output logic en_seen, output logic rst_seen);
    int w = 0;
    lat = 0; en_seen = 0; rst_seen = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1 cmd_valid = 0;
    do begin
      @(negedge clk); lat++;
      en_seen |= lifo_en; rst_seen |= lifo_rst;
    end while (!rsp_valid && lat < 20);
    err = rsp_err; data = rsp_data;
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1 nt++;
    if ({cmd_ready, rsp_valid, rsp_err, sync_err, lifo_en, lifo_rw, lifo_rst, lifo_din, rsp_data} !== 15'd0) begin
      nf++; $display("FAIL reset_hold outputs=%h want 0", {cmd_ready, rsp_valid, rsp_err, sync_err, lifo_en, lifo_rw, lifo_rst, lifo_din, rsp_data});
    end
    @(negedge clk) Rst = 0;
    #1 nt++;
    if ({lifo_en, lifo_rst, cmd_ready, rsp_valid} !== 4'b1100) begin
      nf++; $display("FAIL reset_init en/rst/ready/valid=%b want 1100", {lifo_en, lifo_rst, cmd_ready, rsp_valid});
    end
    repeat (3) begin
      @(negedge clk) nt++;
      if ({lifo_en, lifo_rst, cmd_ready, rsp_valid} !== 4'b0010) begin
        nf++; $display("FAIL reset_idle en/rst/ready/valid=%b want 0010", {lifo_en, lifo_rst, cmd_ready, rsp_valid});
      end
    end
  endtask

  task automatic run_list(input string name, input int n, input logic [1:0] ops [8], input logic [3:0] ds [8],
                          input logic errs [8], input logic [3:0] exd [8]);
    logic e, en, rs; logic [3:0] d; int lat; exp_t x;
    for (int i = 0; i < n; i++) begin
      sbq.push_back('{errs[i], exd[i], errs[i] ? 1 : 3});
      do_cmd(ops[i], ds[i], e, d, lat, en, rs);
      x = sbq.pop_front();
      nt++;
      if (e !== x.err || d !== x.data || lat != x.lat || en !== !x.err) begin
        nf++;
        $display("FAIL %s[%0d] err=%b data=%h lat=%0d en=%b want err=%b data=%h lat=%0d en=%b",
                 name, i, e, d, lat, en, x.err, x.data, x.lat, !x.err);
      end
    end
  endtask

  task automatic test_push_pop;
    run_list("push_pop", 6, '{0, 0, 0, 1, 1, 1, 0, 0}, '{4'h3, 4'h7, 4'hA, 0, 0, 0, 0, 0},
             '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 4'hA, 4'h7, 4'h3, 0, 0});
    nt++;
    if (sync_err !== 1'b0) begin nf++; $display("FAIL push_pop_sync sync_err=%b want 0", sync_err); end
  endtask

  task automatic test_overflow;
    run_list("overflow", 6, '{0, 0, 0, 0, 0, 1, 0, 0}, '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 0, 0, 0},
             '{0, 0, 0, 0, 1, 0, 0, 0}, '{0, 0, 0, 0, 0, 4'h4, 0, 0});
  endtask

  task automatic test_underflow;
    run_list("underflow", 3, '{2, 1, 3, 0, 0, 0, 0, 0}, '{0, 0, 4'hF, 0, 0, 0, 0, 0},
             '{0, 1, 1, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  task automatic test_clear;
    logic e, en, rs; logic [3:0] d; int lat; exp_t x;
    run_list("clear_push", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{4'h9, 0, 0, 0, 0, 0, 0, 0},
             '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    sbq.push_back('{1'b0, 4'h0, 3});
    do_cmd(2'b10, 4'h0, e, d, lat, en, rs);
    x = sbq.pop_front();
    nt++;
    if (e !== x.err || d !== x.data || lat != x.lat || rs !== 1'b1) begin
      nf++; $display("FAIL clear err=%b data=%h lat=%0d rst=%b want err=%b data=%h lat=%0d rst=1", e, d, lat, rs, x.err, x.data, x.lat);
    end
    run_list("clear_pop", 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
             '{1, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  task automatic test_stall_reset;
    int lat = 0, w = 0; exp_t x;
    run_list("stall_push", 2, '{0, 0, 0, 0, 0, 0, 0, 0}, '{4'h5, 4'h6, 0, 0, 0, 0, 0, 0},
             '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    sbq.push_back('{1'b0, 4'h6, 3});
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'b01; cmd_data = 0;
    @(posedge clk); #1 cmd_valid = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    x = sbq.pop_front();
    nt++;
    if (rsp_err !== x.err || rsp_data !== x.data || lat != x.lat) begin
      nf++; $display("FAIL stall_pop err=%b data=%h lat=%0d want err=%b data=%h lat=%0d", rsp_err, rsp_data, lat, x.err, x.data, x.lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) nt++;
      if ({rsp_valid, cmd_ready, rsp_data} !== {2'b10, x.data}) begin
        nf++; $display("FAIL stall_hold[%0d] valid/ready/data=%b want %b", i, {rsp_valid, cmd_ready, rsp_data}, {2'b10, x.data});
      end
    end
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    cmd_valid = 1; cmd_op = 2'b00; cmd_data = 4'hB;
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk) nt++;
    if ({lifo_en, lifo_rw, lifo_din} !== 6'b10_1011) begin
      nf++; $display("FAIL mid_issue en/rw/din=%b want 101011", {lifo_en, lifo_rw, lifo_din});
    end
    Rst = 1;
    #1 nt++;
    if ({cmd_ready, rsp_valid, rsp_err, sync_err, lifo_en, lifo_rw, lifo_rst, lifo_din, rsp_data} !== 15'd0) begin
      nf++; $display("FAIL mid_reset outputs=%h want 0", {cmd_ready, rsp_valid, rsp_err, sync_err, lifo_en, lifo_rw, lifo_rst, lifo_din, rsp_data});
    end
    @(negedge clk) Rst = 0;
    run_list("post_reset_pop", 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
             '{1, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    nt++;
    if (sync_err !== 1'b0) begin nf++; $display("FAIL final_sync sync_err=%b want 0", sync_err); end
  endtask

  initial begin
    test_reset;
    test_push_pop;
    test_overflow;
    test_underflow;
    test_clear;
    test_stall_reset;
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
